expansion_tx: RTL

Transmit-side engine that moves 16-bit words from FPGA fabric out to the BeagleBoard over the FX2 expansion connector. Words are buffered in a small FIFO and driven onto the connector data pins with a slow, source-synchronous strobe, paced by a ready line from the Beagle. It sits between internal sample producers and the connector pins, alongside the existing pin-receive logic.

---
 rtl/expansion_pkg.sv | 16 +
 rtl/expansion_tx_fifo.sv | 63 ++++++
 rtl/expansion_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/expansion_pkg.sv
// Shared definitions for the expansion-connector transmit engine.
// Transmit FSM states and the default word width and strobe pacing.
package expansion_pkg;

    localparam int unsigned EXP_DATA_W         = 16;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;
    localparam int unsigned DEFAULT_STROBE_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/expansion_tx_fifo.sv
// Single-clock show-ahead FIFO that buffers outgoing words for expansion_tx.
// rd_data always presents the head word; rd_en pops it. Pointers wrap modulo DEPTH.
module expansion_tx_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              wr_fire;
    logic              rd_fire;

    assign full    = (count_q == DEPTH_L);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem[rd_ptr_q];
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    // Pointer and occupancy bookkeeping; buffered words are dropped on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_fire && !rd_fire) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!wr_fire && rd_fire) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset since count_q gates visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/expansion_tx.sv
// Transmit engine: buffers fabric words and drives them onto the FX2 expansion
// connector with a slow source-synchronous strobe (SETUP, HIGH, LOW phases of
// STROBE_DIV cycles each), paced by the Beagle's ready line.
// Optional feature: define EXPANSION_TX_PARITY_EN to add the exp_parity output.
module expansion_tx
    import expansion_pkg::*;
#(
    parameter int unsigned DATA_W     = EXP_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned STROBE_DIV = DEFAULT_STROBE_DIV
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          beagle_ready,
    output logic [DATA_W-1:0]             exp_data,
    output logic                          exp_strobe,
`ifdef EXPANSION_TX_PARITY_EN
    output logic                          exp_parity,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int unsigned CW = $clog2(STROBE_DIV) + 1;
    localparam logic [CW-1:0] PHASE_LAST = CW'(STROBE_DIV - 1);

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rdy_meta_q, rdy_s_q;
    logic              pop;
    logic              phase_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;

    expansion_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_valid && in_ready),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Full blocks writes even when a pop lands in the same cycle; low during reset.
    assign in_ready   = !reset && !fifo_full;
    assign exp_data   = data_q;
    assign exp_strobe = (state_q == HIGH);
    assign busy       = (state_q != IDLE);
    assign phase_done = (cnt_q == PHASE_LAST);

    // Two-flop synchronizer for the asynchronous Beagle ready line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
        end else begin
            rdy_meta_q <= beagle_ready;
            rdy_s_q    <= rdy_meta_q;
        end
    end

    // FSM, phase counter and pin data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next-state: a word is only started from IDLE, so a ready drop never aborts one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty && rdy_s_q) begin
                    pop     = 1'b1;
                    data_d  = fifo_rd_data;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (phase_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

`ifdef EXPANSION_TX_PARITY_EN
    logic parity_q;

    // Parity of the loaded word, updated together with the pin data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^fifo_rd_data;
        end
    end

    assign exp_parity = parity_q;
`endif

endmodule
